// File: rtl/dcache_rsp_arb_pkg.sv
// Shared helpers for the dcache response arbiter: index and pointer widths plus the lane word type.
package dcache_rsp_arb_pkg;

    localparam int LANE_WORD_W = 32;
    typedef logic [LANE_WORD_W-1:0] lane_word_t;

    // Index bits appended to the tag; zero when there is a single source.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

    // Round-robin pointer register width; kept at least one bit so it always exists.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dcache_rsp_arb_rr_grant.sv
// Combinational round-robin grant: first valid request at or after i_ptr, wrapping modulo N.
// Produces a one-hot grant and its encoded index.
module dcache_rsp_arb_rr_grant #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_valid,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [PTR_W-1:0] o_idx
);

    logic [N-1:0]   w_rot;
    logic [PTR_W:0] w_sum;
    logic           w_found;

    // NOTE: blocking assignments here are intentional; the loop is a priority chain
    // evaluated in order, and every variable is given a default before the loop.
    always_comb begin
        w_rot   = N'({i_valid, i_valid} >> i_ptr);
        w_sum   = '0;
        w_found = 1'b0;
        o_idx   = '0;
        o_grant = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(N)) begin
                w_sum = w_sum - (PTR_W+1)'(N);
            end
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                o_idx   = w_sum[PTR_W-1:0];
            end
        end
        for (int i = 0; i < N; i++) begin
            o_grant[i] = w_found && (o_idx == PTR_W'(i));
        end
    end

endmodule

// File: rtl/dcache_rsp_arb.sv
// Round-robin merge of NUM_INPUTS dcache response streams into one registered stream.
// Define DCACHE_RSP_ARB_SKID_EN to add a 2-entry skid so rsp_in_ready does not depend on rsp_out_ready.
module dcache_rsp_arb
    import dcache_rsp_arb_pkg::*;
#(
    parameter int  NUM_INPUTS = 4,
    parameter int  NUM_REQS   = 4,
    parameter int  WORD_SIZE  = 4,
    parameter int  TAG_WIDTH  = 8,
    localparam int SEL_W      = sel_w(NUM_INPUTS),
    localparam int WORD_W     = 8 * WORD_SIZE,
    localparam int TAG_OUT_W  = TAG_WIDTH + SEL_W
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_INPUTS-1:0]                 rsp_in_valid,
    input  logic [NUM_INPUTS*NUM_REQS-1:0]        rsp_in_tmask,
    input  logic [NUM_INPUTS*NUM_REQS*WORD_W-1:0] rsp_in_data,
    input  logic [NUM_INPUTS*TAG_WIDTH-1:0]       rsp_in_tag,
    output logic [NUM_INPUTS-1:0]                 rsp_in_ready,
    output logic                                  rsp_out_valid,
    output logic [NUM_REQS-1:0]                   rsp_out_tmask,
    output logic [NUM_REQS*WORD_W-1:0]            rsp_out_data,
    output logic [TAG_OUT_W-1:0]                  rsp_out_tag,
    input  logic                                  rsp_out_ready
);

    localparam int PTR_W  = ptr_w(NUM_INPUTS);
    localparam int LANE_W = NUM_REQS * WORD_W;
    localparam int PL_W   = NUM_REQS + LANE_W + TAG_OUT_W;

    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      w_idx;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic [NUM_INPUTS-1:0] w_grant;
    logic                  w_can_accept;
    logic                  w_accept;
    logic [NUM_REQS-1:0]   w_win_tmask;
    logic [LANE_W-1:0]     w_win_data;
    logic [TAG_WIDTH-1:0]  w_win_tag;
    logic [TAG_OUT_W-1:0]  w_win_tag_out;
    logic [PL_W-1:0]       w_win_pl;

    dcache_rsp_arb_rr_grant #(
        .N     (NUM_INPUTS),
        .PTR_W (PTR_W)
    ) u_rr_grant (
        .i_valid (rsp_in_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    always_comb begin
        w_win_tmask = '0;
        w_win_data  = '0;
        w_win_tag   = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (w_grant[i]) begin
                w_win_tmask = rsp_in_tmask[i*NUM_REQS +: NUM_REQS];
                w_win_data  = rsp_in_data[i*LANE_W +: LANE_W];
                w_win_tag   = rsp_in_tag[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    generate
        if (SEL_W > 0) begin : g_tag_idx
            assign w_win_tag_out = {w_win_tag, w_idx[SEL_W-1:0]};
        end else begin : g_tag_plain
            assign w_win_tag_out = w_win_tag;
        end
    endgenerate

    assign w_win_pl     = {w_win_tmask, w_win_data, w_win_tag_out};
    assign rsp_in_ready = w_grant & {NUM_INPUTS{w_can_accept & ~reset}};
    assign w_accept     = |rsp_in_ready;
    assign w_ptr_nxt    = (w_idx == PTR_W'(NUM_INPUTS-1)) ? '0 : w_idx + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= w_ptr_nxt;
        end
    end

`ifdef DCACHE_RSP_ARB_SKID_EN
    // Two-entry FIFO; entry 0 is the visible output register.
    logic [PL_W-1:0] r_ent0;
    logic [PL_W-1:0] r_ent1;
    logic [1:0]      r_cnt;
    logic            w_pop;

    assign w_can_accept = (r_cnt != 2'd2);
    assign w_pop        = (r_cnt != 2'd0) && rsp_out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= 2'd0;
            r_ent0 <= '0;
            r_ent1 <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_ent0 <= w_win_pl;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= w_win_pl;
                    end
                end
                2'b01: begin
                    r_ent0 <= r_ent1;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_ent0 <= w_win_pl;
                    end else begin
                        r_ent1 <= w_win_pl;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign rsp_out_valid = (r_cnt != 2'd0);
    assign {rsp_out_tmask, rsp_out_data, rsp_out_tag} = r_ent0;
`else
    logic            r_out_valid;
    logic [PL_W-1:0] r_out_pl;

    // Accept while empty or while the consumer drains this cycle; this is a comb path out->in.
    assign w_can_accept = !r_out_valid || rsp_out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_pl    <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_pl    <= w_win_pl;
        end else if (rsp_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign rsp_out_valid = r_out_valid;
    assign {rsp_out_tmask, rsp_out_data, rsp_out_tag} = r_out_pl;
`endif

endmodule

// File: tb/tb_dcache_rsp_arb.sv
// Self-checking bench for dcache_rsp_arb (default build): directed scenarios plus a randomized
// run against a transaction-level round-robin model.
module tb_dcache_rsp_arb;

    localparam int N   = 4;
    localparam int R   = 4;
    localparam int WW  = 32;
    localparam int TW  = 8;
    localparam int SW  = 2;
    localparam int TOW = TW + SW;
    localparam int LW  = R * WW;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     rsp_in_valid;
    logic [N*R-1:0]   rsp_in_tmask;
    logic [N*LW-1:0]  rsp_in_data;
    logic [N*TW-1:0]  rsp_in_tag;
    logic [N-1:0]     rsp_in_ready;
    logic             rsp_out_valid;
    logic [R-1:0]     rsp_out_tmask;
    logic [LW-1:0]    rsp_out_data;
    logic [TOW-1:0]   rsp_out_tag;
    logic             rsp_out_ready;

    dcache_rsp_arb #(
        .NUM_INPUTS (N),
        .NUM_REQS   (R),
        .WORD_SIZE  (WW / 8),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rsp_in_valid  (rsp_in_valid),
        .rsp_in_tmask  (rsp_in_tmask),
        .rsp_in_data   (rsp_in_data),
        .rsp_in_tag    (rsp_in_tag),
        .rsp_in_ready  (rsp_in_ready),
        .rsp_out_valid (rsp_out_valid),
        .rsp_out_tmask (rsp_out_tmask),
        .rsp_out_data  (rsp_out_data),
        .rsp_out_tag   (rsp_out_tag),
        .rsp_out_ready (rsp_out_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic          s_vld   [N];
    logic [R-1:0]  s_tmask [N];
    logic [LW-1:0] s_data  [N];
    logic [TW-1:0] s_tag   [N];

    task automatic new_payload(input int i);
        s_tmask[i] = R'($urandom);
        s_data[i]  = {$urandom, $urandom, $urandom, $urandom};
        s_tag[i]   = TW'($urandom);
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            rsp_in_valid[i]          = s_vld[i];
            rsp_in_tmask[i*R +: R]   = s_tmask[i];
            rsp_in_data[i*LW +: LW]  = s_data[i];
            rsp_in_tag[i*TW +: TW]   = s_tag[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rsp_out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            s_vld[i] = 1'b0;
            new_payload(i);
        end
        apply();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rsp_out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            s_vld[i] = 1'b1;
            new_payload(i);
        end
        apply();
        tick();
        n_cmp++;
        if (rsp_in_ready !== '0) begin
            n_bad++; $display("FAIL reset_ready: got %b expected 0000", rsp_in_ready);
        end
        n_cmp++;
        if (rsp_out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid: got %b expected 0", rsp_out_valid);
        end
        n_cmp++;
        if (rsp_out_tmask !== '0 || rsp_out_tag !== '0) begin
            n_bad++; $display("FAIL reset_regs: tmask %h tag %h expected 0 0", rsp_out_tmask, rsp_out_tag);
        end
        n_cmp++;
        if (rsp_out_data !== '0) begin
            n_bad++; $display("FAIL reset_data: got %h expected 0", rsp_out_data);
        end
    endtask

    task automatic test_round_robin();
        logic [TOW-1:0] e_tag;
        logic [R-1:0]   e_tmask;
        logic [LW-1:0]  e_data;
        int             w;
        do_reset();
        for (int i = 0; i < N; i++) s_vld[i] = 1'b1;
        for (int c = 0; c < 2 * N + 1; c++) begin
            w = c % N;
            apply();
            #1;
            n_cmp++;
            if (rsp_in_ready !== N'(1) << w) begin
                n_bad++; $display("FAIL rr_grant c%0d: got %b expected %b", c, rsp_in_ready, N'(1) << w);
            end
            e_tag = {s_tag[w], SW'(w)};
            e_tmask = s_tmask[w];
            e_data = s_data[w];
            tick();
            n_cmp++;
            if (rsp_out_valid !== 1'b1 || rsp_out_tag !== e_tag || rsp_out_tmask !== e_tmask
                || rsp_out_data !== e_data) begin
                n_bad++; $display("FAIL rr_out c%0d: valid %b tag %h expected valid 1 tag %h", c,
                                  rsp_out_valid, rsp_out_tag, e_tag);
            end
            new_payload(w);
        end
    endtask

    task automatic test_single_source();
        logic [LW-1:0] e_data;
        do_reset();
        s_vld[2] = 1'b1;
        s_tag[2] = 8'h5A;
        s_tmask[2] = 4'b1010;
        e_data = s_data[2];
        apply();
        #1;
        n_cmp++;
        if (rsp_in_ready !== 4'b0100 || rsp_out_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_grant: ready %b valid %b expected 0100 0", rsp_in_ready, rsp_out_valid);
        end
        tick();
        s_vld[2] = 1'b0;
        apply();
        n_cmp++;
        if (rsp_out_valid !== 1'b1 || rsp_out_tag !== 10'h16A || rsp_out_tmask !== 4'b1010
            || rsp_out_data !== e_data) begin
            n_bad++; $display("FAIL single_out: valid %b tag %h tmask %b expected 1 16a 1010",
                              rsp_out_valid, rsp_out_tag, rsp_out_tmask);
        end
        tick();
        n_cmp++;
        if (rsp_out_valid !== 1'b0) begin
            n_bad++; $display("FAIL idle_drain: valid %b expected 0", rsp_out_valid);
        end
    endtask

    task automatic test_stall();
        logic [TOW-1:0] h_tag;
        logic [LW-1:0]  h_data;
        logic [R-1:0]   h_tmask;
        logic [TOW-1:0] e_tag;
        do_reset();
        for (int i = 0; i < N; i++) s_vld[i] = 1'b1;
        apply();
        #1;
        tick();
        new_payload(0);
        rsp_out_ready = 1'b0;
        apply();
        h_tag = rsp_out_tag;
        h_data = rsp_out_data;
        h_tmask = rsp_out_tmask;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if (rsp_in_ready !== '0) begin
                n_bad++; $display("FAIL stall_ready c%0d: got %b expected 0000", c, rsp_in_ready);
            end
            tick();
            n_cmp++;
            if (rsp_out_valid !== 1'b1 || rsp_out_tag !== h_tag || rsp_out_data !== h_data
                || rsp_out_tmask !== h_tmask) begin
                n_bad++; $display("FAIL stall_hold c%0d: tag %h expected %h", c, rsp_out_tag, h_tag);
            end
        end
        rsp_out_ready = 1'b1;
        apply();
        #1;
        n_cmp++;
        if (rsp_in_ready !== 4'b0010) begin
            n_bad++; $display("FAIL stall_ptr: got %b expected 0010", rsp_in_ready);
        end
        e_tag = {s_tag[1], 2'd1};
        tick();
        n_cmp++;
        if (rsp_out_tag !== e_tag) begin
            n_bad++; $display("FAIL stall_resume: tag %h expected %h", rsp_out_tag, e_tag);
        end
    endtask

    task automatic test_wrap();
        logic [TOW-1:0] e_tag;
        do_reset();
        s_vld[2] = 1'b1;
        apply();
        #1;
        tick();
        s_vld[2] = 1'b0;
        s_vld[1] = 1'b1;
        s_vld[3] = 1'b1;
        apply();
        #1;
        n_cmp++;
        if (rsp_in_ready !== 4'b1000) begin
            n_bad++; $display("FAIL wrap_first: got %b expected 1000", rsp_in_ready);
        end
        e_tag = {s_tag[3], 2'd3};
        tick();
        n_cmp++;
        if (rsp_out_tag !== e_tag) begin
            n_bad++; $display("FAIL wrap_tag3: got %h expected %h", rsp_out_tag, e_tag);
        end
        s_vld[3] = 1'b0;
        apply();
        #1;
        n_cmp++;
        if (rsp_in_ready !== 4'b0010) begin
            n_bad++; $display("FAIL wrap_second: got %b expected 0010", rsp_in_ready);
        end
        e_tag = {s_tag[1], 2'd1};
        tick();
        n_cmp++;
        if (rsp_out_tag !== e_tag) begin
            n_bad++; $display("FAIL wrap_tag1: got %h expected %h", rsp_out_tag, e_tag);
        end
        for (int i = 0; i < N; i++) s_vld[i] = 1'b1;
        apply();
        #1;
        n_cmp++;
        if (rsp_in_ready !== 4'b0100) begin
            n_bad++; $display("FAIL wrap_ptr2: got %b expected 0100", rsp_in_ready);
        end
        tick();
    endtask

    task automatic test_tmask_zero();
        logic [TOW-1:0] e_tag;
        do_reset();
        s_vld[1] = 1'b1;
        s_tmask[1] = '0;
        e_tag = {s_tag[1], 2'd1};
        apply();
        #1;
        tick();
        n_cmp++;
        if (rsp_out_valid !== 1'b1 || rsp_out_tmask !== '0 || rsp_out_tag !== e_tag) begin
            n_bad++; $display("FAIL tmask_zero: valid %b tmask %b tag %h expected 1 0000 %h",
                              rsp_out_valid, rsp_out_tmask, rsp_out_tag, e_tag);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < N; i++) s_vld[i] = 1'b1;
        apply();
        #1;
        tick();
        new_payload(0);
        rsp_out_ready = 1'b0;
        reset = 1'b1;
        apply();
        #1;
        n_cmp++;
        if (rsp_in_ready !== '0) begin
            n_bad++; $display("FAIL midrst_ready: got %b expected 0000", rsp_in_ready);
        end
        tick();
        n_cmp++;
        if (rsp_out_valid !== 1'b0 || rsp_out_tag !== '0) begin
            n_bad++; $display("FAIL midrst_out: valid %b tag %h expected 0 0", rsp_out_valid, rsp_out_tag);
        end
        reset = 1'b0;
        rsp_out_ready = 1'b1;
        apply();
        #1;
        n_cmp++;
        if (rsp_in_ready !== 4'b0001) begin
            n_bad++; $display("FAIL midrst_ptr: got %b expected 0001", rsp_in_ready);
        end
        tick();
    endtask

    task automatic test_random();
        int             m_ptr;
        logic           m_vld;
        logic [R-1:0]   m_tmask;
        logic [LW-1:0]  m_data;
        logic [TOW-1:0] m_tag;
        logic [N-1:0]   exp_rdy;
        int             win;
        int             j;
        do_reset();
        m_ptr = 0;
        m_vld = 1'b0;
        m_tmask = '0;
        m_data = '0;
        m_tag = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!s_vld[i] && $urandom_range(0, 99) < 45) begin
                    s_vld[i] = 1'b1;
                    new_payload(i);
                end
            end
            rsp_out_ready = 1'($urandom_range(0, 1));
            apply();
            #1;
            win = -1;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (win < 0 && s_vld[j]) win = j;
            end
            exp_rdy = ((!m_vld || rsp_out_ready) && win >= 0) ? N'(1) << win : '0;
            n_cmp++;
            if (rsp_in_ready !== exp_rdy) begin
                n_bad++; $display("FAIL rand_ready cyc%0d: got %b expected %b", cyc, rsp_in_ready, exp_rdy);
            end
            n_cmp++;
            if (rsp_out_valid !== m_vld) begin
                n_bad++; $display("FAIL rand_valid cyc%0d: got %b expected %b", cyc, rsp_out_valid, m_vld);
            end
            if (m_vld) begin
                n_cmp++;
                if (rsp_out_tag !== m_tag || rsp_out_tmask !== m_tmask || rsp_out_data !== m_data) begin
                    n_bad++; $display("FAIL rand_payload cyc%0d: tag %h tmask %b expected %h %b", cyc,
                                      rsp_out_tag, rsp_out_tmask, m_tag, m_tmask);
                end
            end
            if (exp_rdy != '0) begin
                m_vld = 1'b1;
                m_tmask = s_tmask[win];
                m_data = s_data[win];
                m_tag = {s_tag[win], SW'(win)};
                m_ptr = (win + 1) % N;
                s_vld[win] = 1'b0;
            end else if (rsp_out_ready) begin
                m_vld = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        rsp_out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            s_vld[i] = 1'b0;
            new_payload(i);
        end
        apply();
        test_reset();
        test_round_robin();
        test_single_source();
        test_stall();
        test_wrap();
        test_tmask_zero();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
